// File: rtl/vga_sync_decoder.sv
// Recovers pixel position (row within line, col within frame) from active-low
// VGA sync inputs, and checks line/frame periods to report lock and sync errors.
module vga_sync_decoder #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int LOCK_LINES     = 4,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       visible,
  output logic       h_locked,
  output logic       v_locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int H_TOTAL            = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL            = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int H_MAX              = H_TOTAL - 1;
  localparam int V_MAX              = V_TOTAL - 1;
  localparam int START_H_SYNC_PULSE = H_VISIBLE_AREA + H_FRONT_PORCH;
  localparam int START_V_SYNC_PULSE = V_VISIBLE_AREA + V_FRONT_PORCH;

  localparam logic [9:0] H_MAX_C   = 10'(H_MAX);
  localparam logic [9:0] V_MAX_C   = 10'(V_MAX);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] H_START_C = 10'(START_H_SYNC_PULSE);
  localparam logic [9:0] V_START_C = 10'(START_V_SYNC_PULSE);
  localparam logic [9:0] H_VIS_C   = 10'(H_VISIBLE_AREA);
  localparam logic [9:0] V_VIS_C   = 10'(V_VISIBLE_AREA);
  localparam logic [9:0] PER_SAT   = 10'h3FF;
  localparam logic [3:0] H_LOCK_C  = 4'(LOCK_LINES);
  localparam logic [3:0] V_LOCK_C  = 4'(LOCK_FRAMES);

  function automatic logic [9:0] per_inc(input logic [9:0] p);
    return (p == PER_SAT) ? p : p + 10'd1;
  endfunction

  function automatic logic [3:0] good_inc(input logic [3:0] g, input logic [3:0] lim);
    return (g >= lim) ? lim : g + 4'd1;
  endfunction

  logic       h_s1_p0, h_s2_p1, v_s1_p0, v_s2_p1;
  logic [9:0] h_per, v_per;
  logic [3:0] h_good, v_good;

  logic       h_fall, v_fall, row_wrap, h_clr, h_err, v_err, h_lock_nxt, v_lock_nxt;
  logic [9:0] row_nxt, col_nxt, h_per_nxt, v_per_nxt;
  logic [3:0] h_good_nxt, v_good_nxt;

  // stage 2: edge detect on the synchronised pair, counters and period checks
  always_comb begin
    h_fall     = h_s2_p1 & ~h_s1_p0;
    v_fall     = v_s2_p1 & ~v_s1_p0;
    row_wrap   = !h_fall && (row == H_MAX_C);
    row_nxt    = h_fall ? H_START_C : (row_wrap ? 10'd0 : row + 10'd1);
    col_nxt    = col;
    h_per_nxt  = per_inc(h_per);
    h_good_nxt = h_good;
    h_clr      = 1'b0;
    h_err      = 1'b0;
    v_per_nxt  = h_fall ? per_inc(v_per) : v_per;
    v_good_nxt = v_good;
    v_err      = 1'b0;

    if (v_fall)
      col_nxt = V_START_C;
    else if (row_wrap)
      col_nxt = (col == V_MAX_C) ? 10'd0 : col + 10'd1;

    // a period longer than nominal was already reported by the timeout
    if (h_fall) begin
      h_per_nxt = 10'd0;
      if (h_per == H_MAX_C) begin
        h_good_nxt = good_inc(h_good, H_LOCK_C);
      end else begin
        h_clr = 1'b1;
        h_err = (h_per < H_MAX_C);
      end
    end else if (h_per == H_MAX_C) begin
      h_clr = 1'b1;
      h_err = 1'b1;
    end

    if (v_fall) begin
      v_per_nxt = h_fall ? 10'd1 : 10'd0;
      if (v_per == V_TOTAL_C) begin
        v_good_nxt = good_inc(v_good, V_LOCK_C);
      end else begin
        v_good_nxt = 4'd0;
        v_err      = (v_per < V_TOTAL_C);
      end
    end else if (h_fall && (v_per == V_TOTAL_C)) begin
      v_good_nxt = 4'd0;
      v_err      = 1'b1;
    end

    if (h_clr) begin
      h_good_nxt = 4'd0;
      v_good_nxt = 4'd0;
    end

    h_lock_nxt = (h_good_nxt == H_LOCK_C);
    v_lock_nxt = (v_good_nxt == V_LOCK_C) && h_lock_nxt;
  end

  // stage 0/1: two-register input pipeline; stage 3: registered outputs
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_s1_p0     <= 1'b1;
      h_s2_p1     <= 1'b1;
      v_s1_p0     <= 1'b1;
      v_s2_p1     <= 1'b1;
      row         <= 10'd0;
      col         <= 10'd0;
      h_per       <= PER_SAT;
      v_per       <= PER_SAT;
      h_good      <= 4'd0;
      v_good      <= 4'd0;
      h_locked    <= 1'b0;
      v_locked    <= 1'b0;
      visible     <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      h_s1_p0     <= h_sync;
      h_s2_p1     <= h_s1_p0;
      v_s1_p0     <= v_sync;
      v_s2_p1     <= v_s1_p0;
      row         <= row_nxt;
      col         <= col_nxt;
      h_per       <= h_per_nxt;
      v_per       <= v_per_nxt;
      h_good      <= h_good_nxt;
      v_good      <= v_good_nxt;
      h_locked    <= h_lock_nxt;
      v_locked    <= v_lock_nxt;
      visible     <= h_lock_nxt && v_lock_nxt && (row_nxt < H_VIS_C) && (col_nxt < V_VIS_C);
      frame_start <= h_lock_nxt && v_lock_nxt && (row_nxt == 10'd0) && (col_nxt == 10'd0);
      sync_err    <= h_err | v_err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with reduced timing (25 pixels x 13 lines) so that
// lock acquisition, fault recovery and stuck-sync cases fit in a short run.
module tb_vga_sync_decoder;
  localparam int HV = 16, HFP = 2, HSP = 4, HBP = 3;
  localparam int VV = 8, VFP = 1, VSP = 2, VBP = 2;
  localparam int HT = HV + HFP + HSP + HBP;
  localparam int VT = VV + VFP + VSP + VBP;

  logic       pixel_clk = 1'b0;
  logic       reset, h_sync, v_sync;
  logic [9:0] row, col;
  logic       visible, h_locked, v_locked, frame_start, sync_err;

  always #5 pixel_clk = ~pixel_clk;

  vga_sync_decoder #(
    .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
    .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
    .LOCK_LINES(4), .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .row(row), .col(col), .visible(visible), .h_locked(h_locked), .v_locked(v_locked),
    .frame_start(frame_start), .sync_err(sync_err)
  );

  // -1 in any expected field means "not checked at this point"
  typedef struct {
    int kk; int hl; int vl; int err; int vis; int fs; int r; int c;
  } chk_t;

  chk_t clean_tab [7];
  chk_t fault_tab [16];
  chk_t stuck_tab [3];

  int   checks = 0, errors = 0;
  int   kk, gr, gc, line_len, frame_len;
  int   prev_r, prev_c;
  logic prev_v;
  logic stuck, faults_en;
  int   err_pulses, fs_pulses, vis_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, kk, act, exp);
    end
  endtask

  // Drive one cycle of the reference generator, then check the decoded outputs
  // against the generator position applied two cycles earlier.
  task automatic tick();
    logic cur_v;
    logic in_fault;
    if (faults_en && kk == 1375) line_len = HT + 1;
    if (faults_en && kk == 2276) frame_len = VT + 1;
    h_sync = stuck ? 1'b1 : !(gr >= HV + HFP && gr < HV + HFP + HSP);
    v_sync = stuck ? 1'b1 : !(gc >= VV + VFP && gc < VV + VFP + VSP);
    cur_v  = (gr < HV) && (gc < VV);
    @(posedge pixel_clk);
    #1;
    kk++;
    in_fault = faults_en && ((kk >= 1375 && kk < 1853) || (kk >= 2276 && kk < 3503));
    if (!in_fault && h_locked && v_locked) begin
      check("row", 16'(row), 16'(prev_r));
      check("col", 16'(col), 16'(prev_c));
      check("visible", 16'(visible), 16'(prev_v));
    end
    if (sync_err) err_pulses++;
    if (visible) vis_cnt++;
    if (frame_start) begin
      fs_pulses++;
      check("frame_start_pos", 16'({row, col, visible}), 16'(1));
    end
    prev_r = gr;
    prev_c = gc;
    prev_v = cur_v;
    if (gr == line_len - 1) begin
      gr       = 0;
      line_len = HT;
      if (gc == frame_len - 1) begin
        gc        = 0;
        frame_len = VT;
      end else gc++;
    end else gr++;
  endtask

  task automatic run_until(input int t);
    while (kk < t) tick();
  endtask

  task automatic check_point(input chk_t c);
    run_until(c.kk);
    if (c.hl  >= 0) check("h_locked",    16'(h_locked),    16'(c.hl));
    if (c.vl  >= 0) check("v_locked",    16'(v_locked),    16'(c.vl));
    if (c.err >= 0) check("sync_err",    16'(sync_err),    16'(c.err));
    if (c.vis >= 0) check("visible",     16'(visible),     16'(c.vis));
    if (c.fs  >= 0) check("frame_start", 16'(frame_start), 16'(c.fs));
    if (c.r   >= 0) check("row_point",   16'(row),         16'(c.r));
    if (c.c   >= 0) check("col_point",   16'(col),         16'(c.c));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_row"}, 16'(row), 16'(0));
    check({tag, "_col"}, 16'(col), 16'(0));
    check({tag, "_vis"}, 16'(visible), 16'(0));
    check({tag, "_hl"},  16'(h_locked), 16'(0));
    check({tag, "_vl"},  16'(v_locked), 16'(0));
    check({tag, "_fs"},  16'(frame_start), 16'(0));
    check({tag, "_err"}, 16'(sync_err), 16'(0));
  endtask

  task automatic restart();
    gr = 0; gc = 0; line_len = HT; frame_len = VT; kk = 0;
    prev_r = 0; prev_c = 0; prev_v = 1'b0;
    err_pulses = 0; fs_pulses = 0; vis_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic run_clean();
    for (int i = 0; i < $size(clean_tab); i++) check_point(clean_tab[i]);
    check("clean_err_pulses", 16'(err_pulses), 16'(0));
    check("clean_fs_pulses",  16'(fs_pulses),  16'(2));
  endtask

  initial begin
    //                kk    hl  vl  err vis fs  row col
    clean_tab[0] = '{ 119,  0,  0,  0, -1, -1, -1, -1};
    clean_tab[1] = '{ 120,  1,  0,  0,  0, -1, -1, -1};
    clean_tab[2] = '{ 876,  1,  0, -1, -1, -1, -1, -1};
    clean_tab[3] = '{ 877,  1,  1,  0, -1, -1, -1, -1};
    clean_tab[4] = '{ 977,  1,  1, -1,  1,  1,  0,  0};
    clean_tab[5] = '{ 978, -1, -1, -1, -1,  0, -1, -1};
    clean_tab[6] = '{1302,  1,  1, -1,  1,  1,  0,  0};

    fault_tab[0]  = '{1419,  1,  1,  0, -1, -1, -1, -1};
    fault_tab[1]  = '{1420,  0,  0,  1,  0, -1, -1, -1};
    fault_tab[2]  = '{1421, -1, -1,  0, -1, -1, -1, -1};
    fault_tab[3]  = '{1520,  0, -1, -1, -1, -1, -1, -1};
    fault_tab[4]  = '{1521,  1,  0, -1, -1, -1, -1, -1};
    fault_tab[5]  = '{1852,  1,  0, -1, -1, -1, -1, -1};
    fault_tab[6]  = '{1853,  1,  1,  0, -1, -1, -1, -1};
    fault_tab[7]  = '{1952, -1, -1, -1, -1,  0, -1, -1};
    fault_tab[8]  = '{1953,  1,  1, -1,  1,  1,  0,  0};
    fault_tab[9]  = '{2845,  1,  1,  0, -1, -1, -1, -1};
    fault_tab[10] = '{2846,  1,  0,  1,  0, -1, -1, -1};
    fault_tab[11] = '{2847,  1, -1,  0, -1, -1, -1, -1};
    fault_tab[12] = '{2853, -1, -1,  0, -1, -1, -1, -1};
    fault_tab[13] = '{3502,  1,  0, -1, -1, -1, -1, -1};
    fault_tab[14] = '{3503,  1,  1, -1, -1, -1, -1, -1};
    fault_tab[15] = '{3738,  1,  1,  0,  1, -1, 10,  5};

    stuck_tab[0] = '{1330,  1,  1,  0,  1, -1,  3,  1};
    stuck_tab[1] = '{1369,  1,  1,  0, -1, -1, -1, -1};
    stuck_tab[2] = '{1370,  0,  0,  1,  0, -1, -1, -1};

    reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    stuck = 1'b0; faults_en = 1'b0; kk = 0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_zero_outputs("reset");

    // Clean lock from reset, then a stretched line and a long frame
    faults_en = 1'b1;
    restart();
    run_clean();
    for (int i = 0; i < $size(fault_tab); i++) check_point(fault_tab[i]);

    // Asynchronous reset mid-frame: outputs clear before the next clock edge
    #1;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(posedge pixel_clk);
    #1;
    faults_en = 1'b0;
    restart();
    run_clean();

    // Both syncs stuck high: a single timeout pulse, then silence
    check_point(stuck_tab[0]);
    run_until(1350);
    stuck = 1'b1;
    check_point(stuck_tab[1]);
    check_point(stuck_tab[2]);
    vis_cnt = 0;
    run_until(2450);
    check("stuck_err_pulses", 16'(err_pulses), 16'(1));
    check("stuck_visible",    16'(vis_cnt),    16'(0));
    check("stuck_h_locked",   16'(h_locked),   16'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
